// File: rtl/enemy_hit_receiver.sv
// ============================================================================
// Module   : enemy_hit_receiver
// Brief    : Decides whether the player attack strikes one enemy and tracks
//            that enemy's health, invulnerability and death sequence.
//            Optional macro ATTACK_EDGE_ONLY_EN: one hit per attack press.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_hit_receiver #(
    parameter int SHORT         = 16,
    parameter int LONG          = 80,
    parameter int ENEMY_SIZE    = 20,
    parameter int MAX_HEALTH    = 100,
    parameter int DAMAGE        = 25,
    parameter int INVULN_FRAMES = 30,
    parameter int DEATH_FRAMES  = 45
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       game_frame_clk_rising_edge,
    input  logic       Spawn,
    input  logic       Attack_On,
    input  logic [8:0] Attack_X,
    input  logic [8:0] Attack_Y,
    input  logic [1:0] Attack_Direction,
    input  logic [8:0] Enemy_X,
    input  logic [8:0] Enemy_Y,
    output logic [7:0] Enemy_Health,
    output logic [1:0] Enemy_State,
    output logic       Enemy_Alive,
    output logic       Flash,
    output logic       Hit_Pulse,
    output logic       Kill_Pulse
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ALIVE  = 2'd1;
    localparam logic [1:0] S_INVULN = 2'd2;
    localparam logic [1:0] S_DYING  = 2'd3;

    localparam logic [9:0] c_SHORT = 10'(SHORT);
    localparam logic [9:0] c_LONG  = 10'(LONG);
    localparam logic [9:0] c_ESIZE = 10'(ENEMY_SIZE);
    localparam logic [7:0] c_MAXH  = 8'(MAX_HEALTH);
    localparam logic [7:0] c_DMG   = 8'(DAMAGE);
    localparam logic [5:0] c_INV   = 6'(INVULN_FRAMES);
    localparam logic [5:0] c_DEATH = 6'(DEATH_FRAMES);

    logic [1:0] r_state;
    logic [7:0] r_health;
    logic [5:0] r_cnt;
    logic       r_hit;
    logic       r_kill;

    logic [9:0] w_ax, w_ay, w_ex, w_ey;
    logic       w_overlap;
    logic       w_hit_req;

    assign w_ax = {1'b0, Attack_X};
    assign w_ay = {1'b0, Attack_Y};
    assign w_ex = {1'b0, Enemy_X};
    assign w_ey = {1'b0, Enemy_Y};

    // Comparisons only (no subtraction) so 9-bit positions never underflow.
    always_comb begin
        w_overlap = 1'b0;
        case (Attack_Direction)
            2'd0: w_overlap = (w_ax < w_ex + c_ESIZE) && (w_ex < w_ax + c_SHORT) &&
                              (w_ay < w_ey + c_ESIZE) && (w_ey < w_ay + c_LONG);
            2'd1: w_overlap = (w_ex < w_ax) && (w_ax < w_ex + c_ESIZE + c_LONG) &&
                              (w_ay < w_ey + c_ESIZE) && (w_ey < w_ay + c_SHORT);
            2'd2: w_overlap = (w_ax < w_ex + c_ESIZE) && (w_ex < w_ax + c_SHORT) &&
                              (w_ey < w_ay) && (w_ay < w_ey + c_ESIZE + c_LONG);
            default: w_overlap = (w_ax < w_ex + c_ESIZE) && (w_ex < w_ax + c_LONG) &&
                                 (w_ay < w_ey + c_ESIZE) && (w_ey < w_ay + c_SHORT);
        endcase
    end

`ifdef ATTACK_EDGE_ONLY_EN
    logic r_atk_prev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_atk_prev <= 1'b0;
        else if (game_frame_clk_rising_edge)
            r_atk_prev <= Attack_On;
    end

    assign w_hit_req = Attack_On && !r_atk_prev && w_overlap;
`else
    assign w_hit_req = Attack_On && w_overlap;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_health <= 8'd0;
            r_cnt    <= 6'd0;
            r_hit    <= 1'b0;
            r_kill   <= 1'b0;
        end else begin
            r_hit  <= 1'b0;
            r_kill <= 1'b0;
            if (Spawn) begin
                r_state  <= S_ALIVE;
                r_health <= c_MAXH;
                r_cnt    <= 6'd0;
            end else if (game_frame_clk_rising_edge) begin
                case (r_state)
                    S_ALIVE: begin
                        if (w_hit_req) begin
                            if (r_health > c_DMG) begin
                                r_health <= r_health - c_DMG;
                                r_hit    <= 1'b1;
                                r_cnt    <= c_INV;
                                r_state  <= S_INVULN;
                            end else begin
                                r_health <= 8'd0;
                                r_kill   <= 1'b1;
                                r_cnt    <= c_DEATH;
                                r_state  <= S_DYING;
                            end
                        end
                    end
                    S_INVULN: begin
                        if (r_cnt == 6'd1) begin
                            r_cnt   <= 6'd0;
                            r_state <= S_ALIVE;
                        end else begin
                            r_cnt <= r_cnt - 6'd1;
                        end
                    end
                    S_DYING: begin
                        if (r_cnt == 6'd1) begin
                            r_cnt   <= 6'd0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 6'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Enemy_State  = r_state;
    assign Enemy_Health = r_health;
    assign Enemy_Alive  = (r_state == S_ALIVE) || (r_state == S_INVULN);
    assign Flash        = ((r_state == S_INVULN) || (r_state == S_DYING)) && r_cnt[1];
    assign Hit_Pulse    = r_hit;
    assign Kill_Pulse   = r_kill;

endmodule

`default_nettype wire
